ripple_count_ctrl: RTL and testbench
====================================

# ripple_count_ctrl

Synchronous measurement controller for the 12-bit asynchronous ripple counter. Each measurement clears the counter, opens an event gate for a programmed number of `clk` cycles, waits for ripple settling, and samples the count safely into the `clk` domain. The result and an overflow flag are delivered over a valid/ack handshake. The block sits between the counter instance and the system register or consumer logic.

## Interface
- `WIDTH`, 12: counter width; matches the ripple counter.
- `GATE_W`, 16: width of the gate-window length.
- `SETTLE`, 4: number of `clk` cycles to wait after the gate closes before sampling (≥1).
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a measurement; sampled only in IDLE.
- `window` in GATE_W: gate length in `clk` cycles; latched on an accepted `start`.
- `cnt_clr` out 1: active-high clear to the ripple counter.
- `cnt_en` out 1: gate enable; counter clock = event AND `cnt_en`, formed externally.
- `cnt_q` in WIDTH: counter outputs, asynchronous to `clk`.
- `busy` out 1: high in every state except IDLE.
- `result` out WIDTH: captured count.
- `ovf` out 1: counter wrapped at least once during the measurement.
- `valid` out 1: `result`/`ovf` are valid.
- `ack` in 1: consumer accepts the result.

## Operation
- `cnt_q` passes through a 2-flop synchronizer (`sq`) before any use.
- States:
  - IDLE: on `start`=1, latch `window` and go to CLEAR.
  - CLEAR (1 cycle): `cnt_clr`=1, clear `ovf`; go to GATE, or to SETTLE if the latched window is 0.
  - GATE: `cnt_en`=1 for exactly `window` cycles; go to SETTLE.
  - SETTLE: lasts `SETTLE` cycles with `cnt_en`=0; go to SAMPLE.
  - SAMPLE: each cycle, register `sq` into `prev`. When `sq`==`prev` (two consecutive equal samples), load `result`=`sq` and go to VALID.
  - VALID: `valid`=1 and `result`/`ovf` held stable until `ack`=1; then go to IDLE.
- Overflow:
  - `ovf` is sticky from CLEAR+1 through SAMPLE.
  - It sets when the synchronized MSB `sq[WIDTH-1]` is seen 1 and then 0 on a later cycle.
  - Wraps faster than the synchronizer can observe are outside the block's scope.
- Ignored inputs:
  - `start` is ignored in every state except IDLE.
  - `ack` is ignored outside VALID.
- Count arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset values: `cnt_clr`=0, `cnt_en`=0, `busy`=0, `valid`=0, `ovf`=0, `result`=0, state=IDLE, synchronizer and `prev` all 0.
- Latency, with `start` accepted at edge N and a counter already stable in SETTLE:
  - CLEAR at N+1.
  - GATE from N+2 to N+1+W.
  - SETTLE for the next `SETTLE` cycles.
  - SAMPLE cycles 1–2.
  - `valid` rises at N+4+W+SETTLE.
  - With W=0: `valid` rises at N+4+SETTLE.
- Handshake:
  - Transfer happens on the edge where `valid`=1 and `ack`=1.
  - `valid` falls on the next cycle; `busy` falls with it.
  - A new `start` is accepted no earlier than the first IDLE cycle.
- Reset mid-measurement: all outputs return immediately to their reset values, the gate closes, and the pending result is discarded.

## Configuration
- `RIPPLE_CTRL_AUTORESTART_EN`
  - Defined: on the `ack` edge in VALID, if `start`=1 the FSM goes directly to CLEAR using the previously latched window. This gives back-to-back measurements with no IDLE cycle, and `busy` stays high. If `start`=0, it goes to IDLE.
  - Undefined: VALID always returns to IDLE, and `start` is sampled only there.

## Test plan
- Events at 1 per 2 `clk`, `start` with `window`=100 → `result`=50 ±1, `ovf`=0, `valid` at N+4+100+SETTLE.
- `window`=0 → no `cnt_en` pulse, `result`=0, `valid` at N+4+SETTLE.
- Events every `clk`, `window`=5000 → `ovf`=1, `result`=5000 mod 4096 = 904 (±1).
- `ack` held low for 20 cycles → `valid`, `result` and `ovf` remain stable; `start` pulses during that time are ignored and `busy`=1 throughout.
- `reset` driven low during GATE → `cnt_en`, `busy`, `valid` and `result` are 0 asynchronously; the next `start` runs a full, correct measurement.
- With `RIPPLE_CTRL_AUTORESTART_EN` defined and `start` tied high, `window`=10 → consecutive results with CLEAR on the cycle after each `ack`, and `busy` never deasserts.

Source files
------------

// File: rtl/ripple_count_ctrl.sv
// Measurement controller for a 12-bit asynchronous ripple counter: clear, gate, settle, sample, handshake.
// Optional build macro RIPPLE_CTRL_AUTORESTART_EN: start held at ack restarts directly with the latched window.
module ripple_count_ctrl #(
  parameter int WIDTH  = 12,
  parameter int GATE_W = 16,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [GATE_W-1:0] window_i,
  output logic              cnt_clr_o,
  output logic              cnt_en_o,
  input  logic [WIDTH-1:0]  cnt_q_i,
  output logic              busy_o,
  output logic [WIDTH-1:0]  result_o,
  output logic              ovf_o,
  output logic              valid_o,
  input  logic              ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_SAMPLE, S_VALID
  } state_e;

  localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(SETTLE - 1);
  localparam logic [GATE_W-1:0] ONE         = GATE_W'(1);

  state_e            state_q, state_d;
  logic [GATE_W-1:0] window_q, window_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic [WIDTH-1:0]  sync1_q, sync1_d;
  logic [WIDTH-1:0]  sq_q, sq_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              msb_seen_q, msb_seen_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      window_q   <= '0;
      timer_q    <= '0;
      sync1_q    <= '0;
      sq_q       <= '0;
      prev_q     <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      msb_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      timer_q    <= timer_d;
      sync1_q    <= sync1_d;
      sq_q       <= sq_d;
      prev_q     <= prev_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      msb_seen_q <= msb_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    timer_d    = timer_q;
    sync1_d    = cnt_q_i;
    sq_d       = sync1_q;
    prev_d     = prev_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    msb_seen_d = msb_seen_q;

    // Wrap detection: MSB observed high, then low on a later cycle.
    if (state_q == S_GATE || state_q == S_SETTLE || state_q == S_SAMPLE) begin
      if (sq_q[WIDTH-1]) msb_seen_d = 1'b1;
      if (msb_seen_q && !sq_q[WIDTH-1]) ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          window_d = window_i;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // Counter is held cleared now, so drop stale pre-clear samples from the synchronizer.
        sync1_d    = '0;
        sq_d       = '0;
        ovf_d      = 1'b0;
        msb_seen_d = 1'b0;
        if (window_q == '0) begin
          state_d = S_SETTLE;
          timer_d = SETTLE_LAST;
        end else begin
          state_d = S_GATE;
          timer_d = window_q - ONE;
        end
      end
      S_GATE: begin
        if (timer_q == '0) begin
          state_d = S_SETTLE;
          timer_d = SETTLE_LAST;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) begin
          state_d = S_SAMPLE;
          timer_d = ONE;
        end else begin
          timer_d = timer_q - ONE;
        end
      end
      S_SAMPLE: begin
        prev_d = sq_q;
        // First sample cycle only primes prev; comparison starts on the second.
        if (timer_q != '0) begin
          timer_d = '0;
        end else if (sq_q == prev_q) begin
          result_d = sq_q;
          state_d  = S_VALID;
        end
      end
      S_VALID: begin
        if (ack_i) begin
`ifdef RIPPLE_CTRL_AUTORESTART_EN
          state_d = start_i ? S_CLEAR : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_clr_o = (state_q == S_CLEAR);
  assign cnt_en_o  = (state_q == S_GATE);
  assign busy_o    = (state_q != S_IDLE);
  assign valid_o   = (state_q == S_VALID);
  assign result_o  = result_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Bench for ripple_count_ctrl: behavioural ripple counter fed by an asynchronous event clock,
// results checked against event-rate arithmetic (window / event period, modulo 4096).
module tb_ripple_count_ctrl;
  localparam int WIDTH  = 12;
  localparam int GATE_W = 16;
  localparam int SETTLE = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              ack = 1'b0;
  logic [GATE_W-1:0] window = '0;
  logic              cnt_clr, cnt_en, busy, valid, ovf;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  ctr = '0;
  logic              ev = 1'b0;
  int                ev_half = 5;
  int                tests = 0;
  int                fails = 0;

  ripple_count_ctrl #(.WIDTH(WIDTH), .GATE_W(GATE_W), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .window_i (window),
    .cnt_clr_o(cnt_clr),
    .cnt_en_o (cnt_en),
    .cnt_q_i  (ctr),
    .busy_o   (busy),
    .result_o (result),
    .ovf_o    (ovf),
    .valid_o  (valid),
    .ack_i    (ack)
  );

  always #5 clk = ~clk;

  // Event edges sit at 3 mod 5 time units, never on a clk edge.
  initial begin
    #3;
    forever #(ev_half) ev = ~ev;
  end

  // External ripple counter: clocked by event AND gate, asynchronous clear.
  always @(posedge ev or posedge cnt_clr) begin
    if (cnt_clr) ctr <= '0;
    else if (cnt_en) ctr <= ctr + 1'b1;
  end

  task automatic launch(input int w, input int k, output logic clr_seen);
    @(negedge clk);
    ev_half = 5 * k;
    window  = GATE_W'(w);
    start   = 1'b1;
    @(posedge clk);
    #1;
    clr_seen = cnt_clr;
    start    = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int lat, output int en,
                            output bit busy_low, output bit timeout);
    lat = 0; en = 0; busy_low = 0; timeout = 1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (cnt_en) en++;
      if (!busy) busy_low = 1;
      if (valid) begin
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic do_ack(input string name);
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_ack: valid=%0b busy=%0b, expected valid=0 busy=0", name, valid, busy);
    end
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({cnt_clr, cnt_en, busy, valid, ovf} !== 5'b0 || result !== '0) begin
      fails++;
      $display("FAIL reset_outputs: clr=%0b en=%0b busy=%0b valid=%0b ovf=%0b result=%0d, expected all 0",
               cnt_clr, cnt_en, busy, valid, ovf, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%0b valid=%0b, expected 0 0", busy, valid);
    end
  endtask

  task automatic test_measurement(input string name, input int w, input int k);
    logic clr; int lat, en, exp_cnt; bit bl, to; logic [WIDTH-1:0] d;
    logic exp_ovf;
    exp_cnt = w / k;
    exp_ovf = (exp_cnt >= 4096);
    launch(w, k, clr);
    tests++;
    if (clr !== 1'b1) begin
      fails++; $display("FAIL %s_clear: cnt_clr=%0b, expected 1", name, clr);
    end
    wait_valid(w + 50, lat, en, bl, to);
    tests++;
    if (to) begin
      fails++; $display("FAIL %s_timeout: valid=0 after %0d cycles, expected valid", name, lat);
      return;
    end
    tests++;
    if (lat != 3 + w + SETTLE) begin
      fails++; $display("FAIL %s_latency: got %0d, expected %0d", name, lat, 3 + w + SETTLE);
    end
    tests++;
    if (en != w) begin
      fails++; $display("FAIL %s_gate_cycles: got %0d, expected %0d", name, en, w);
    end
    tests++;
    if (bl) begin
      fails++; $display("FAIL %s_busy: busy dropped=1, expected 0", name);
    end
    d = result - WIDTH'(exp_cnt % 4096);
    tests++;
    if (!(d == 0 || d == 1 || d == {WIDTH{1'b1}})) begin
      fails++; $display("FAIL %s_result: got %0d, expected %0d +-1", name, result, exp_cnt % 4096);
    end
    tests++;
    if (ovf !== exp_ovf) begin
      fails++; $display("FAIL %s_ovf: got %0b, expected %0b", name, ovf, exp_ovf);
    end
    do_ack(name);
  endtask

  task automatic test_zero_window();
    test_measurement("zero_window", 0, 1);
    tests++;
    if (result !== '0) begin
      fails++; $display("FAIL zero_window_exact: got %0d, expected 0", result);
    end
  endtask

  task automatic test_random();
    int w, k;
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(1, 2000);
      k = $urandom_range(1, 4);
      $display("[TB] random measurement %0d: window=%0d period=%0d", i, w, k);
      test_measurement("random", w, k);
    end
    w = $urandom_range(4300, 7000);
    $display("[TB] random overflow measurement: window=%0d period=1", w);
    test_measurement("random_ovf", w, 1);
  endtask

  task automatic test_hold();
    logic clr; int lat, en; bit bl, to; logic [WIDTH-1:0] snap, d;
    launch(30, 1, clr);
    wait_valid(100, lat, en, bl, to);
    tests++;
    if (to) begin
      fails++; $display("FAIL hold_timeout: valid=0, expected valid"); return;
    end
    snap = result;
    d = snap - WIDTH'(30);
    tests++;
    if (!(d == 0 || d == 1 || d == {WIDTH{1'b1}})) begin
      fails++; $display("FAIL hold_result: got %0d, expected 30 +-1", snap);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start  = 1'($urandom_range(0, 1));
      window = GATE_W'($urandom);
      @(posedge clk);
      #1;
      tests++;
      if (valid !== 1'b1 || busy !== 1'b1 || result !== snap || ovf !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable: valid=%0b busy=%0b result=%0d ovf=%0b, expected 1 1 %0d 0",
                 valid, busy, result, ovf, snap);
      end
    end
    @(negedge clk);
    start = 1'b0;
    do_ack("hold");
  endtask

  task automatic test_reset_mid();
    logic clr;
    launch(200, 1, clr);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cnt_clr, cnt_en, busy, valid, ovf} !== 5'b0 || result !== '0) begin
      fails++;
      $display("FAIL reset_mid: clr=%0b en=%0b busy=%0b valid=%0b ovf=%0b result=%0d, expected all 0",
               cnt_clr, cnt_en, busy, valid, ovf, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_measurement("after_reset", 60, 1);
  endtask

  task automatic test_back_to_back();
    int lat, en; bit bl, to; logic [WIDTH-1:0] d;
    @(negedge clk);
    ev_half = 5;
    window  = GATE_W'(10);
    start   = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (cnt_clr !== 1'b1) begin
      fails++; $display("FAIL b2b_first_clear: cnt_clr=%0b, expected 1", cnt_clr);
    end
`ifdef RIPPLE_CTRL_AUTORESTART_EN
    for (int r = 0; r < 3; r++) begin
      wait_valid(100, lat, en, bl, to);
      tests++;
      if (to || lat != 3 + 10 + SETTLE || bl) begin
        fails++;
        $display("FAIL b2b_run%0d: timeout=%0b latency=%0d busy_dropped=%0b, expected 0 %0d 0",
                 r, to, lat, bl, 3 + 10 + SETTLE);
      end
      d = result - WIDTH'(10);
      tests++;
      if (!(d == 0 || d == 1 || d == {WIDTH{1'b1}})) begin
        fails++; $display("FAIL b2b_result%0d: got %0d, expected 10 +-1", r, result);
      end
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      tests++;
      if (cnt_clr !== 1'b1 || busy !== 1'b1 || valid !== 1'b0) begin
        fails++;
        $display("FAIL b2b_restart%0d: clr=%0b busy=%0b valid=%0b, expected 1 1 0", r, cnt_clr, busy, valid);
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_valid(100, lat, en, bl, to);
    tests++;
    if (to) begin
      fails++; $display("FAIL b2b_final_timeout: valid=0, expected valid");
    end
    do_ack("b2b_final");
`else
    wait_valid(100, lat, en, bl, to);
    tests++;
    if (to || lat != 3 + 10 + SETTLE) begin
      fails++;
      $display("FAIL b2b_run: timeout=%0b latency=%0d, expected 0 %0d", to, lat, 3 + 10 + SETTLE);
    end
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++; $display("FAIL b2b_idle: busy=%0b valid=%0b, expected 0 0", busy, valid);
    end
    @(posedge clk);
    #1;
    tests++;
    if (cnt_clr !== 1'b1) begin
      fails++; $display("FAIL b2b_next_clear: cnt_clr=%0b, expected 1", cnt_clr);
    end
    start = 1'b0;
    wait_valid(100, lat, en, bl, to);
    d = result - WIDTH'(10);
    tests++;
    if (to || !(d == 0 || d == 1 || d == {WIDTH{1'b1}})) begin
      fails++; $display("FAIL b2b_second: timeout=%0b result=%0d, expected 0 and 10 +-1", to, result);
    end
    do_ack("b2b_second");
`endif
  endtask

  initial begin
    test_reset();
    $display("[TB] basic: window=100 period=2");
    test_measurement("basic", 100, 2);
    $display("[TB] zero window");
    test_zero_window();
    $display("[TB] overflow: window=5000 period=1");
    test_measurement("overflow", 5000, 1);
    test_random();
    $display("[TB] ack held low with ignored starts");
    test_hold();
    $display("[TB] reset during gate");
    test_reset_mid();
    $display("[TB] back to back");
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
